ulpi_reg_write_ctrl: RTL and testbench

- Link-side ULPI register-write engine that sits between the top-level PHY bring-up sequencer and the USB3300-style ULPI PHY pins.
- Accepts one register-write request at a time from the sequencer.
- Performs the ULPI TX CMD / data / STP handshake under DIR/NXT control, and retries the write when the PHY takes the bus.
- While DIR is high, captures RX CMD bytes and exports LINESTATE to the downstream chirp and reset-detect logic.

---
 rtl/ulpi_pkg.sv | 36 +++
 rtl/ulpi_rxcmd_capture.sv | 50 +++++
 rtl/ulpi_reg_write_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ulpi_reg_write_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// ---------------------------------------------------------------------------
// ulpi_pkg
// Shared ULPI constants for the link-side register-write engine:
//   - TX CMD prefixes and the NOOP bus value
//   - immediate register addresses used by the bring-up sequencer
//   - engine state encoding
//   - LINESTATE codes carried in RX CMD bits [1:0]
// No ports (package).
// ---------------------------------------------------------------------------
package ulpi_pkg;

  localparam logic [1:0] TXCMD_REGW = 2'b10;
  localparam logic [1:0] TXCMD_REGR = 2'b11;
  localparam logic [7:0] TXCMD_NOOP = 8'h00;

  localparam logic [5:0] REG_FUNC_CTRL = 6'h04;
  localparam logic [5:0] REG_OTG_CTRL  = 6'h0A;

  localparam logic [1:0] LINESTATE_SE0 = 2'b00;
  localparam logic [1:0] LINESTATE_J   = 2'b01;
  localparam logic [1:0] LINESTATE_K   = 2'b10;

  typedef enum logic [2:0] {
    ST_TURN,
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_STOP
  } state_t;

  // TX CMD byte for an immediate register write to 'addr'.
  function automatic logic [7:0] reg_write_cmd(input logic [5:0] addr);
    return {TXCMD_REGW, addr};
  endfunction

endpackage

// File: rtl/ulpi_rxcmd_capture.sv
// ---------------------------------------------------------------------------
// ulpi_rxcmd_capture
// Tracks the registered ULPI DIR, flags bus turnaround cycles and captures
// RX CMD bytes while the PHY owns the bus.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   dir, nxt        ULPI DIR / NXT from the PHY
//   data_in         sampled ULPI data
//   turnaround      1 while DIR differs from its registered copy
//   rxcmd_valid     one-cycle pulse after a new RX CMD was captured
//   rxcmd           last RX CMD byte
//   linestate       rxcmd[1:0], held between captures
// ---------------------------------------------------------------------------
module ulpi_rxcmd_capture (
  input  logic       clk,
  input  logic       rst,
  input  logic       dir,
  input  logic       nxt,
  input  logic [7:0] data_in,
  output logic       turnaround,
  output logic       rxcmd_valid,
  output logic [7:0] rxcmd,
  output logic [1:0] linestate
);

  logic dir_q;

  // A byte is an RX CMD only once the PHY has owned the bus for a full
  // cycle (the turnaround cycle carries no valid data) and NXT is low;
  // NXT high marks packet data, which is not this block's business.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q       <= 1'b0;
      rxcmd_valid <= 1'b0;
      rxcmd       <= 8'h00;
      linestate   <= 2'b00;
    end else begin
      dir_q       <= dir;
      rxcmd_valid <= 1'b0;
      if (dir && dir_q && !nxt) begin
        rxcmd       <= data_in;
        linestate   <= data_in[1:0];
        rxcmd_valid <= 1'b1;
      end
    end
  end

  assign turnaround = dir ^ dir_q;

endmodule

// File: rtl/ulpi_reg_write_ctrl.sv
// ---------------------------------------------------------------------------
// ulpi_reg_write_ctrl
// Link-side ULPI register-write engine: takes one write request at a time,
// runs the TX CMD / data / STP handshake under DIR/NXT control, retries the
// write when the PHY grabs the bus, and exports RX CMD / LINESTATE.
// Ports:
//   CLK, RST                     60 MHz ULPI clock, sync active-high reset
//   REQ_VALID/ADDR/DATA/READY    request handshake from the sequencer
//   DONE, ERROR                  one-cycle completion / failure pulses
//   ULPI_DATA_OUT, ULPI_DATA_OE  link-driven data and its output enable
//   ULPI_DATA_IN, ULPI_DIR,
//   ULPI_NXT, ULPI_STP           remaining ULPI PHY pins
//   RXCMD_VALID, RXCMD, LINESTATE  captured RX CMD information
// ---------------------------------------------------------------------------
module ulpi_reg_write_ctrl
  import ulpi_pkg::*;
#(
  parameter int unsigned NXT_TIMEOUT = 255,
  parameter int unsigned RETRY_MAX   = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  input  logic [5:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       REQ_READY,
  output logic       DONE,
  output logic       ERROR,
  output logic [7:0] ULPI_DATA_OUT,
  output logic       ULPI_DATA_OE,
  input  logic [7:0] ULPI_DATA_IN,
  input  logic       ULPI_DIR,
  input  logic       ULPI_NXT,
  output logic       ULPI_STP,
  output logic       RXCMD_VALID,
  output logic [7:0] RXCMD,
  output logic [1:0] LINESTATE
);

  localparam int TMO_W   = (NXT_TIMEOUT < 2) ? 1 : $clog2(NXT_TIMEOUT + 1);
  localparam int RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(NXT_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

  state_t             state;
  logic [5:0]         addr_q;
  logic [7:0]         data_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic               retry_pending;
  logic               timed_out;
  logic               abort_err;
  logic               turnaround;
  logic               stop_cycle;

  ulpi_rxcmd_capture u_rxcmd (
    .clk        (CLK),
    .rst        (RST),
    .dir        (ULPI_DIR),
    .nxt        (ULPI_NXT),
    .data_in    (ULPI_DATA_IN),
    .turnaround (turnaround),
    .rxcmd_valid(RXCMD_VALID),
    .rxcmd      (RXCMD),
    .linestate  (LINESTATE)
  );

  // Engine FSM. The PHY raising DIR always sends us to TURN, so a DIR
  // falling edge is only ever seen from TURN. An abort either schedules a
  // retry of the latched request (taken when TURN sees DIR low) or, once
  // the retry budget is spent, drops the request with an ERROR pulse on the
  // following cycle. A timeout still issues the STP cycle, flagged as an
  // error instead of a completion.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_TURN;
      addr_q        <= '0;
      data_q        <= '0;
      tmo_cnt       <= '0;
      retry_cnt     <= '0;
      retry_pending <= 1'b0;
      timed_out     <= 1'b0;
      abort_err     <= 1'b0;
    end else begin
      abort_err <= 1'b0;
      case (state)
        ST_TURN: begin
          if (!ULPI_DIR) begin
            if (retry_pending) begin
              retry_pending <= 1'b0;
              tmo_cnt       <= '0;
              state         <= ST_CMD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (ULPI_DIR) begin
            state <= ST_TURN;
          end else if (REQ_VALID) begin
            addr_q    <= REQ_ADDR;
            data_q    <= REQ_DATA;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            timed_out <= 1'b0;
            state     <= ST_CMD;
          end
        end
        ST_CMD, ST_DATA: begin
          if (ULPI_DIR) begin
            state <= ST_TURN;
            if (retry_cnt == RETRY_LIM) begin
              abort_err     <= 1'b1;
              retry_pending <= 1'b0;
            end else begin
              retry_cnt     <= retry_cnt + RETRY_W'(1);
              retry_pending <= 1'b1;
            end
          end else if (ULPI_NXT) begin
            tmo_cnt <= '0;
            state   <= (state == ST_CMD) ? ST_DATA : ST_STOP;
          end else if (tmo_cnt == TMO_LAST) begin
            timed_out <= 1'b1;
            state     <= ST_STOP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_STOP: begin
          // DIR high here means STP was never driven: treat as an abort,
          // except that an already timed-out request is simply dropped.
          if (ULPI_DIR) begin
            state <= ST_TURN;
            if (timed_out || retry_cnt == RETRY_LIM) begin
              abort_err     <= 1'b1;
              retry_pending <= 1'b0;
              timed_out     <= 1'b0;
            end else begin
              retry_cnt     <= retry_cnt + RETRY_W'(1);
              retry_pending <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_TURN;
      endcase
    end
  end

  // The link must release the bus in the very cycle DIR is seen high, so
  // the enable and STP are qualified combinationally by DIR.
  assign stop_cycle    = (state == ST_STOP) && !ULPI_DIR;
  assign REQ_READY     = (state == ST_IDLE) && !ULPI_DIR;
  assign ULPI_DATA_OE  = (state != ST_TURN) && !ULPI_DIR && !turnaround;
  assign ULPI_STP      = stop_cycle;
  assign DONE          = stop_cycle && !timed_out;
  assign ERROR         = (stop_cycle && timed_out) || abort_err;

  always_comb begin
    ULPI_DATA_OUT = TXCMD_NOOP;
    case (state)
      ST_CMD:  ULPI_DATA_OUT = reg_write_cmd(addr_q);
      ST_DATA: ULPI_DATA_OUT = data_q;
      default: ULPI_DATA_OUT = TXCMD_NOOP;
    endcase
  end

endmodule

// File: tb/tb_ulpi_reg_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ulpi_reg_write_ctrl
// Directed bench for ulpi_reg_write_ctrl. Expected bus events are queued
// when a step is driven and matched against what the DUT produces.
// ---------------------------------------------------------------------------
module tb_ulpi_reg_write_ctrl;
  import ulpi_pkg::*;

  localparam logic [3:0] EV_BYTE  = 4'h1;
  localparam logic [3:0] EV_DONE  = 4'h2;
  localparam logic [3:0] EV_TOERR = 4'h3;
  localparam logic [3:0] EV_ABERR = 4'h4;
  localparam logic [3:0] EV_RX    = 4'h5;
  localparam logic [3:0] EV_BAD   = 4'hF;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [5:0] req_addr;
  logic [7:0] req_data;
  logic       req_ready;
  logic       done;
  logic       error;
  logic [7:0] data_out;
  logic       oe;
  logic [7:0] data_in;
  logic       dir;
  logic       nxt;
  logic       stp;
  logic       rxcmd_valid;
  logic [7:0] rxcmd;
  logic [1:0] linestate;

  int check_count = 0;
  int error_count = 0;
  int cycles;
  logic [15:0] exp_q[$];

  ulpi_reg_write_ctrl #(.NXT_TIMEOUT(255), .RETRY_MAX(3)) dut (
    .CLK          (clk),
    .RST          (rst),
    .REQ_VALID    (req_valid),
    .REQ_ADDR     (req_addr),
    .REQ_DATA     (req_data),
    .REQ_READY    (req_ready),
    .DONE         (done),
    .ERROR        (error),
    .ULPI_DATA_OUT(data_out),
    .ULPI_DATA_OE (oe),
    .ULPI_DATA_IN (data_in),
    .ULPI_DIR     (dir),
    .ULPI_NXT     (nxt),
    .ULPI_STP     (stp),
    .RXCMD_VALID  (rxcmd_valid),
    .RXCMD        (rxcmd),
    .LINESTATE    (linestate)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ev(input logic oe_bit, input logic [3:0] kind,
                                     input logic [7:0] d);
    return {oe_bit, 3'b000, kind, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    check_count++;
    assert (observed === expected)
    else begin
      error_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic scoreEvent(input logic [15:0] observed);
    if (exp_q.size() == 0) begin
      check_count++;
      assert (exp_q.size() != 0)
      else begin
        error_count++;
        $error("[TB] FAIL scoreboard observed=%h expected=none", observed);
      end
    end else begin
      checkOutput("scoreboard", observed, exp_q.pop_front());
    end
  endtask

  // One clock cycle: inputs change just after the rising edge, and the
  // task returns at the falling edge so outputs can be sampled.
  task automatic applyStimulus(input logic r, input logic v, input logic [5:0] a,
                               input logic [7:0] d, input logic dr, input logic nx,
                               input logic [7:0] di);
    @(posedge clk);
    #1;
    rst = r; req_valid = v; req_addr = a; req_data = d;
    dir = dr; nxt = nx; data_in = di;
    @(negedge clk);
  endtask

  task automatic busCycle(input logic dr, input logic nx, input logic [7:0] di);
    applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, dr, nx, di);
  endtask

  task automatic reqCycle(input logic [5:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, a, d, 1'b0, 1'b0, 8'h00);
  endtask

  // Bus monitor: every observable event is matched against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (stp) begin
        scoreEvent(ev(oe, (done && !error) ? EV_DONE :
                          ((error && !done) ? EV_TOERR : EV_BAD), data_out));
      end else begin
        if (oe && nxt) scoreEvent(ev(1'b1, EV_BYTE, data_out));
        if (error) scoreEvent(ev(1'b0, EV_ABERR, 8'h00));
        if (done) scoreEvent(ev(1'b0, EV_BAD, 8'h00));
      end
      if (rxcmd_valid) scoreEvent(ev(1'b0, EV_RX, rxcmd));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 6'h00; req_data = 8'h00;
    dir = 1'b0; nxt = 1'b0; data_in = 8'h00;

    // Reset state
    applyStimulus(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("reset_ready", 16'(req_ready), 16'h0);
    checkOutput("reset_oe", 16'(oe), 16'h0);
    checkOutput("reset_stp_done_err", 16'({stp, done, error}), 16'h0);
    checkOutput("reset_out", 16'(data_out), 16'h00);
    checkOutput("reset_rx", 16'({rxcmd_valid, linestate, rxcmd}), 16'h0);

    // Release: one TURN cycle, then idle
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("turn_ready", 16'(req_ready), 16'h0);
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("idle_ready", 16'(req_ready), 16'h1);
    checkOutput("idle_oe", 16'(oe), 16'h1);

    // Basic write 0x0A <= 0x00
    exp_q.push_back(ev(1'b1, EV_BYTE, 8'h8A));
    exp_q.push_back(ev(1'b1, EV_BYTE, 8'h00));
    exp_q.push_back(ev(1'b1, EV_DONE, 8'h00));
    reqCycle(REG_OTG_CTRL, 8'h00);
    busCycle(1'b0, 1'b1, 8'h00);
    checkOutput("basic_cmd", 16'({oe, data_out}), 16'h18A);
    busCycle(1'b0, 1'b1, 8'h00);
    checkOutput("basic_data", 16'({oe, data_out}), 16'h100);
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("basic_stop", 16'({stp, done, error}), 16'b110);
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("basic_ready_again", 16'(req_ready), 16'h1);

    // Throttle: 5 stall cycles with NXT low, then NXT accepts the TX CMD
    exp_q.push_back(ev(1'b1, EV_BYTE, 8'h84));
    exp_q.push_back(ev(1'b1, EV_BYTE, 8'h65));
    exp_q.push_back(ev(1'b1, EV_DONE, 8'h00));
    reqCycle(REG_FUNC_CTRL, 8'h65);
    for (int i = 0; i < 5; i++) begin
      busCycle(1'b0, 1'b0, 8'h00);
      checkOutput("throttle_hold", 16'(data_out), 16'h84);
    end
    busCycle(1'b0, 1'b1, 8'h00);
    busCycle(1'b0, 1'b1, 8'h00);
    checkOutput("throttle_data", 16'(data_out), 16'h65);
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("throttle_stop", 16'({stp, done, error}), 16'b110);
    busCycle(1'b0, 1'b0, 8'h00);

    // Abort during DATA (DIR beats a pending NXT), retry after DIR falls
    exp_q.push_back(ev(1'b1, EV_BYTE, 8'h84));
    exp_q.push_back(ev(1'b1, EV_BYTE, 8'h84));
    exp_q.push_back(ev(1'b1, EV_BYTE, 8'h54));
    exp_q.push_back(ev(1'b1, EV_DONE, 8'h00));
    reqCycle(REG_FUNC_CTRL, 8'h54);
    busCycle(1'b0, 1'b1, 8'h00);
    busCycle(1'b1, 1'b1, 8'h00);
    checkOutput("abort_oe_drop", 16'(oe), 16'h0);
    for (int i = 0; i < 9; i++) busCycle(1'b1, 1'b1, 8'h00);
    checkOutput("abort_ready_low", 16'(req_ready), 16'h0);
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("abort_turn_oe", 16'(oe), 16'h0);
    busCycle(1'b0, 1'b1, 8'h00);
    checkOutput("retry_cmd", 16'({oe, data_out}), 16'h184);
    busCycle(1'b0, 1'b1, 8'h00);
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("retry_done", 16'({stp, done, error}), 16'b110);
    busCycle(1'b0, 1'b0, 8'h00);

    // RX CMD: turnaround byte ignored, NXT-high byte ignored
    exp_q.push_back(ev(1'b0, EV_RX, 8'h54));
    exp_q.push_back(ev(1'b0, EV_RX, 8'h4E));
    applyStimulus(1'b0, 1'b1, REG_OTG_CTRL, 8'hFF, 1'b1, 1'b0, 8'h55);
    checkOutput("rx_ready_dir_high", 16'(req_ready), 16'h0);
    applyStimulus(1'b0, 1'b1, REG_OTG_CTRL, 8'hFF, 1'b1, 1'b0, 8'h54);
    busCycle(1'b1, 1'b1, 8'hAA);
    checkOutput("rx_first", 16'({linestate, rxcmd}), 16'({LINESTATE_SE0, 8'h54}));
    busCycle(1'b1, 1'b0, 8'h4E);
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("rx_second", 16'({linestate, rxcmd}), 16'({LINESTATE_K, 8'h4E}));
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("rx_no_accept", 16'({req_ready, linestate}), 16'({1'b1, LINESTATE_K}));

    // Four aborts in CMD: three retries, then ERROR and the request drops
    exp_q.push_back(ev(1'b0, EV_ABERR, 8'h00));
    reqCycle(REG_OTG_CTRL, 8'h33);
    for (int i = 0; i < 4; i++) begin
      busCycle(1'b1, 1'b1, 8'h00);
      busCycle(1'b0, 1'b0, 8'h00);
    end
    checkOutput("retry_exhaust_err", 16'({error, done}), 16'b10);
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("retry_exhaust_idle", 16'({req_ready, error}), 16'b10);

    // Timeout: NXT never comes
    exp_q.push_back(ev(1'b1, EV_TOERR, 8'h00));
    reqCycle(REG_FUNC_CTRL, 8'h11);
    cycles = 0;
    do begin
      busCycle(1'b0, 1'b0, 8'h00);
      cycles++;
    end while (!stp && cycles < 400);
    checkOutput("timeout_latency", 16'(cycles), 16'd256);
    checkOutput("timeout_flags", 16'({stp, done, error}), 16'b101);
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("timeout_ready", 16'(req_ready), 16'h1);

    // Reset in the middle of DATA
    exp_q.push_back(ev(1'b1, EV_BYTE, 8'h84));
    reqCycle(REG_FUNC_CTRL, 8'h77);
    busCycle(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("rst_mid_outs", 16'({oe, stp, done, req_ready}), 16'h0);
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("rst_mid_turn", 16'(req_ready), 16'h0);
    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("rst_mid_ready", 16'(req_ready), 16'h1);

    busCycle(1'b0, 1'b0, 8'h00);
    checkOutput("scoreboard_drained", 16'(exp_q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
